// File: rtl/instr_fetch_unit_pkg.sv
// Shared instruction-set definitions for the fetch side: opcode/register encodings,
// instruction field slices and the fetch sequencer state encoding.
`ifndef INSTR_FETCH_UNIT_DEFS
`define INSTR_FETCH_UNIT_DEFS
`define NOP 4'h0
`define JMP 4'h1
`define BLE 4'h2
`define STO 4'h3
`define R0 8'h00
`define R1 8'h01
`define R2 8'h02
`define R3 8'h03
`define R4 8'h04
`define R5 8'h05
`define R6 8'h06
`define R7 8'h07
`define IFU_OPC(i) i[27:24]
`define IFU_DST(i) i[23:16]
`define IFU_SRC1(i) i[15:8]
`define IFU_SRC0(i) i[7:0]
`define IFU_LIT(i) i[15:0]
`define IFU_DLY(i) i[23:0]
`define IFU_ST_FETCH 1'b0
`define IFU_ST_DELAY 1'b1
`endif

package instr_fetch_unit_pkg;
    localparam int IFU_ADDR_W  = 16;
    localparam int IFU_INSTR_W = 28;
    localparam int IFU_OPC_W   = 4;
    localparam int IFU_DLY_W   = 24;

    typedef enum logic {
        ST_FETCH = `IFU_ST_FETCH,
        ST_DELAY = `IFU_ST_DELAY
    } ifu_state_e;
endpackage

// File: rtl/instr_fetch_unit_delay_counter.sv
// Down-counter for NOP delays: clear beats load beats decrement; zero flag from the register.
module fetch_delay_counter
    import instr_fetch_unit_pkg::*;
#(
    parameter int DLY_W = IFU_DLY_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [DLY_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    // next count selection
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {DLY_W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - DLY_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {DLY_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {DLY_W{1'b0}});
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: drives the ROM address, registers instructions toward decode
// with valid/ready, absorbs NOP delays and applies execute redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = IFU_ADDR_W,
    parameter int INSTR_W = IFU_INSTR_W,
    parameter int OPC_W   = IFU_OPC_W,
    parameter int DLY_W   = IFU_DLY_W
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oRomAddress,
    input  logic [INSTR_W-1:0] iRomInstruction,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oInstrPC,
    output logic               oInstrValid,
    input  logic               iInstrReady,
    input  logic               iRedirect,
    input  logic [ADDR_W-1:0]  iRedirectTarget,
    output logic               oBusyDelay
);
    ifu_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic               valid_q, valid_d;
    logic               slot_free_s;
    logic               is_nop_s;
    logic               cnt_clr_s, cnt_load_s, cnt_dec_s, cnt_zero_s;

    assign slot_free_s = !valid_q || iInstrReady;
    assign is_nop_s    = (iRomInstruction[INSTR_W-1 -: OPC_W] == `NOP);

    fetch_delay_counter #(.DLY_W(DLY_W)) u_dly (
        .clk_i      (Clock),
        .rst_n_i    (Reset),
        .clr_i      (cnt_clr_s),
        .load_i     (cnt_load_s),
        .load_val_i (iRomInstruction[DLY_W-1:0]),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // next-state: redirect first, then fetch/stall or delay countdown
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
        valid_d    = valid_q;
        cnt_clr_s  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        if (iRedirect) begin
            // a same-cycle handshake already delivered its instruction; only the slot is flushed
            pc_d      = iRedirectTarget;
            valid_d   = 1'b0;
            cnt_clr_s = 1'b1;
            state_d   = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (slot_free_s) begin
                        pc_d = pc_q + ADDR_W'(1);
                        if (!is_nop_s) begin
                            instr_d = iRomInstruction;
                            ipc_d   = pc_q;
                            valid_d = 1'b1;
                        end else begin
                            valid_d    = 1'b0;
                            cnt_load_s = 1'b1;
                            state_d    = ST_DELAY;
                        end
                    end else begin
                        pc_d = pc_q;
                    end
                end
                ST_DELAY: begin
                    if (iInstrReady) begin
                        valid_d = 1'b0;
                    end else begin
                        valid_d = valid_q;
                    end
                    if (cnt_zero_s) begin
                        state_d = ST_FETCH;
                    end else begin
                        cnt_dec_s = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // sequencer registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_FETCH;
            pc_q    <= {ADDR_W{1'b0}};
            instr_q <= {INSTR_W{1'b0}};
            ipc_q   <= {ADDR_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign oRomAddress  = pc_q;
    assign oInstruction = instr_q;
    assign oInstrPC     = ipc_q;
    assign oInstrValid  = valid_q;
    assign oBusyDelay   = (state_q == ST_DELAY);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a behavioural combinational ROM.
module tb_instr_fetch_unit;
    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_STO = 4'h3;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] oRomAddress;
    logic [27:0] iRomInstruction;
    logic [27:0] oInstruction;
    logic [15:0] oInstrPC;
    logic        oInstrValid;
    logic        iInstrReady;
    logic        iRedirect;
    logic [15:0] iRedirectTarget;
    logic        oBusyDelay;

    logic [27:0] rom [65536];
    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;
    assign iRomInstruction = rom[oRomAddress];

    instr_fetch_unit dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .oRomAddress     (oRomAddress),
        .iRomInstruction (iRomInstruction),
        .oInstruction    (oInstruction),
        .oInstrPC        (oInstrPC),
        .oInstrValid     (oInstrValid),
        .iInstrReady     (iInstrReady),
        .iRedirect       (iRedirect),
        .iRedirectTarget (iRedirectTarget),
        .oBusyDelay      (oBusyDelay)
    );

    function automatic logic [27:0] sto_word(input logic [15:0] a);
        return {OPC_STO, 8'h01, a};
    endfunction

    task automatic fill_rom();
        for (int a = 0; a < 65536; a++) rom[a] = sto_word(16'(a));
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        iRedirect = 1'b0;
        iRedirectTarget = 16'h0000;
        iInstrReady = 1'b1;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    task automatic expect_valid(input string name, input logic [15:0] pc);
        checks++;
        if (oInstrValid !== 1'b1 || oInstrPC !== pc || oInstruction !== rom[pc]) begin
            errors++;
            $display("FAIL %s: valid=%b pc=%h instr=%h, expected valid=1 pc=%h instr=%h",
                     name, oInstrValid, oInstrPC, oInstruction, pc, rom[pc]);
        end
    endtask

    task automatic test_reset();
        fill_rom();
        Reset = 1'b0;
        iRedirect = 1'b0;
        iRedirectTarget = 16'h0000;
        iInstrReady = 1'b1;
        #3;
        checks++;
        if (oRomAddress !== 16'h0000 || oInstruction !== 28'h0 || oInstrPC !== 16'h0000 ||
            oInstrValid !== 1'b0 || oBusyDelay !== 1'b0) begin
            errors++;
            $display("FAIL reset: addr=%h instr=%h pc=%h valid=%b busy=%b, expected all zero",
                     oRomAddress, oInstruction, oInstrPC, oInstrValid, oBusyDelay);
        end
        tick();
    endtask

    task automatic test_sequential_and_backpressure();
        Reset = 1'b1;
        checks++;
        if (oInstrValid !== 1'b0) begin
            errors++;
            $display("FAIL release_valid: valid=%b, expected 0 before first edge", oInstrValid);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_valid("sequential", 16'(k));
        end
        iInstrReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_valid("stall_hold", 16'h0005);
            checks++;
            if (oRomAddress !== 16'h0006) begin
                errors++;
                $display("FAIL stall_addr: addr=%h, expected 0006", oRomAddress);
            end
        end
        iInstrReady = 1'b1;
        tick();
        expect_valid("after_stall", 16'h0006);
    endtask

    task automatic test_nop_delay();
        logic       exp_busy [6];
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fill_rom();
        rom[0] = {OPC_NOP, 24'd3};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (oBusyDelay !== exp_busy[k] || oInstrValid !== 1'b0) begin
                errors++;
                $display("FAIL nop3 cycle %0d: busy=%b valid=%b, expected busy=%b valid=0",
                         k + 1, oBusyDelay, oInstrValid, exp_busy[k]);
            end
        end
        tick();
        expect_valid("nop3_next", 16'h0001);
    endtask

    task automatic test_nop_zero();
        fill_rom();
        rom[0] = {OPC_NOP, 24'd0};
        do_reset();
        tick();
        checks++;
        if (oBusyDelay !== 1'b1 || oInstrValid !== 1'b0) begin
            errors++;
            $display("FAIL nop0_delay: busy=%b valid=%b, expected busy=1 valid=0", oBusyDelay, oInstrValid);
        end
        tick();
        checks++;
        if (oBusyDelay !== 1'b0 || oInstrValid !== 1'b0) begin
            errors++;
            $display("FAIL nop0_exit: busy=%b valid=%b, expected busy=0 valid=0", oBusyDelay, oInstrValid);
        end
        tick();
        expect_valid("nop0_next", 16'h0001);
    endtask

    task automatic test_redirect();
        fill_rom();
        rom[40] = {OPC_NOP, 24'd4000};
        do_reset();
        for (int k = 0; k < 17; k++) tick();
        expect_valid("pre_redirect", 16'h0010);
        iInstrReady = 1'b0;
        iRedirect = 1'b1;
        iRedirectTarget = 16'h0002;
        tick();
        iRedirect = 1'b0;
        iInstrReady = 1'b1;
        checks++;
        if (oInstrValid !== 1'b0 || oRomAddress !== 16'h0002) begin
            errors++;
            $display("FAIL redirect_flush: valid=%b addr=%h, expected valid=0 addr=0002", oInstrValid, oRomAddress);
        end
        tick();
        expect_valid("redirect_target", 16'h0002);
        iRedirect = 1'b1;
        iRedirectTarget = 16'd40;
        tick();
        iRedirect = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (oBusyDelay !== 1'b1 || oInstrValid !== 1'b0) begin
            errors++;
            $display("FAIL long_delay: busy=%b valid=%b, expected busy=1 valid=0", oBusyDelay, oInstrValid);
        end
        iRedirect = 1'b1;
        iRedirectTarget = 16'h0002;
        tick();
        iRedirect = 1'b0;
        checks++;
        if (oBusyDelay !== 1'b0 || oInstrValid !== 1'b0 || oRomAddress !== 16'h0002) begin
            errors++;
            $display("FAIL delay_redirect: busy=%b valid=%b addr=%h, expected busy=0 valid=0 addr=0002",
                     oBusyDelay, oInstrValid, oRomAddress);
        end
        tick();
        expect_valid("delay_redirect_target", 16'h0002);
    endtask

    task automatic test_wrap_and_async_reset();
        rom[1] = {OPC_NOP, 24'd100};
        iRedirect = 1'b1;
        iRedirectTarget = 16'hFFFF;
        tick();
        iRedirect = 1'b0;
        tick();
        expect_valid("wrap_ffff", 16'hFFFF);
        tick();
        expect_valid("wrap_0000", 16'h0000);
        tick();
        tick();
        tick();
        checks++;
        if (oBusyDelay !== 1'b1) begin
            errors++;
            $display("FAIL wrap_nop_busy: busy=%b, expected 1", oBusyDelay);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (oRomAddress !== 16'h0000 || oInstruction !== 28'h0 || oInstrPC !== 16'h0000 ||
            oInstrValid !== 1'b0 || oBusyDelay !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: addr=%h instr=%h pc=%h valid=%b busy=%b, expected all zero",
                     oRomAddress, oInstruction, oInstrPC, oInstrValid, oBusyDelay);
        end
        tick();
        Reset = 1'b1;
        tick();
        expect_valid("restart", 16'h0000);
    endtask

    initial begin
        test_reset();
        test_sequential_and_backpressure();
        test_nop_delay();
        test_nop_zero();
        test_redirect();
        test_wrap_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Sequencer on the read side of the instruction ROM. It drives the ROM address (the PC), registers the returned 28-bit instruction, and presents it to decode over a valid/ready handshake. NOP-with-count instructions are absorbed here as timed delays and are never forwarded. Branch and jump redirects from execute are accepted here. It sits between the combinational ROM and the decode/execute stage.

Parameters:
ADDR_W, 16, PC and ROM address width
INSTR_W, 28, instruction width: opcode[27:24], dest[23:16], src1[15:8], src0[7:0]; literal in [15:0]
OPC_W, 4, opcode field width, [INSTR_W-1 -: OPC_W]
DLY_W, 24, NOP delay count width: instruction bits [23:0]

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
oRomAddress  out  ADDR_W  ROM address; equals the PC register, combinational from the register
iRomInstruction  in  INSTR_W  ROM data; combinational in oRomAddress, valid in the same cycle
oInstruction  out  INSTR_W  registered instruction to decode
oInstrPC  out  ADDR_W  address oInstruction was fetched from
oInstrValid  out  1  oInstruction is valid
iInstrReady  in  1  decode accepts; a transfer occurs when oInstrValid and iInstrReady are both high
iRedirect  in  1  taken branch or jump, single-cycle pulse
iRedirectTarget  in  ADDR_W  new PC, sampled when iRedirect is high
oBusyDelay  out  1  high while in DELAY state

Behaviour:
- Reset (asynchronous, Reset low): PC=0, oInstruction=0, oInstrPC=0, oInstrValid=0, delay counter=0, state=FETCH, oBusyDelay=0.
- Define slot_free = !oInstrValid || iInstrReady.
- FETCH, slot_free, opcode != `NOP:
  - oInstruction <= iRomInstruction; oInstrPC <= PC; oInstrValid <= 1; PC <= PC+1.
  - Sustained throughput is 1 instruction per cycle.
- FETCH, slot_free, opcode == `NOP:
  - oInstrValid <= 0.
  - cnt <= iRomInstruction[23:0]; PC <= PC+1; state <= DELAY.
- FETCH, !slot_free: hold PC, oInstruction, oInstrPC and oInstrValid unchanged (stall). The ROM address stays stable.
- DELAY:
  - oBusyDelay=1; no fetch.
  - A pending valid output may still drain: if iInstrReady, oInstrValid <= 0.
  - If cnt==0, go to FETCH next cycle; else cnt <= cnt-1.
  - A NOP with count N therefore occupies N+2 cycles: 1 fetch cycle plus N+1 DELAY cycles.
- Redirect has highest priority in any state:
  - PC <= iRedirectTarget; oInstrValid <= 0, flushing any unaccepted instruction; cnt <= 0; state <= FETCH.
  - The first fetch from the target is valid 1 cycle later, i.e. 2 clocks after the iRedirect edge.
- Redirect in the same cycle as a handshake: the transfer counts as accepted (decode consumed it), and the flush applies to the next slot.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF + 1 = 0. No error flag is raised.
- Latency:
  - The instruction at address 0 is valid on the first rising edge after Reset deasserts.
  - A PC change reaches oRomAddress with 0 extra cycles.
- Reset mid-DELAY or mid-stall aborts immediately; fetch restarts at address 0.
- Opcodes other than `NOP are passed through uninterpreted. JMP/BLE resolution belongs to execute, which returns iRedirect.

Decomposition:
- Opcode and register encodings (`NOP, `JMP, `BLE, `R0..`R7) come from the shared definitions header; no local literals.
- Add to the header:
  - Opcode field slice macros.
  - FETCH/DELAY state encoding, 1 bit.
- Natural sub-module: fetch_delay_counter (DLY_W down-counter with load, zero flag, clear). Everything else stays in instr_fetch_unit.

Test Plan:
- Reset release, ROM holds non-NOP at 0..3, iInstrReady=1 -> oInstrPC sequence 0,1,2,3 on consecutive cycles; oInstrValid rises 1 cycle after release.
- Backpressure: iInstrReady=0 for 3 cycles while address 5 is valid -> oInstruction and oInstrPC=5 held stable, oRomAddress=6 stable; after release 6 follows next cycle.
- NOP with count 3 at address 0, STO at 1 -> oBusyDelay high 4 cycles; address 1 valid exactly 5 cycles after first fetch; NOP never presented.
- NOP count 0 -> one DELAY cycle; next instruction valid 2 cycles after the NOP fetch.
- Redirect to 2 while address 16 valid and unaccepted, and also during a 4000-cycle delay -> valid drops, next oInstrPC=2, oBusyDelay clears.
- PC wrap: redirect to 16'hFFFF -> oInstrPC FFFF then 0000. Reset asserted mid-delay -> outputs 0 asynchronously, restart at address 0.
